wb_stage: RTL
=============

# wb_stage

Writeback stage of the 64-bit in-order core. It accepts one retiring instruction per cycle from the memory stage, waits for the data-memory response on loads, and aligns and extends the load data. It then drives the single write port of the integer register file (`we`/`waddr`/`wdata`) and reports each committed PC. The register file forwards same-cycle writes to its read ports, so this stage needs no bypass network of its own.

## Interface
Parameters: none (widths fixed at XLEN = 64).

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  64  instruction PC
- in_rd  in  5  destination register index
- in_rd_we  in  1  instruction writes rd
- in_result  in  64  ALU result; for loads, the effective address
- in_is_load  in  1  instruction is a load
- in_ld_funct3  in  3  load funct3 (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110)
- dmem_rvalid  in  1  load response valid, exactly one per issued load
- dmem_rdata  in  64  doubleword-aligned load data
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write index
- rf_wdata  out  64  register-file write data
- commit_valid  out  1  instruction retires this cycle
- commit_pc  out  64  PC of the retiring instruction

## Operation
- One entry register holds pc, rd, rd_we, is_load, funct3, offset = in_result[2:0], and data.
- Transfer occurs when in_valid && in_ready.
- FSM states:
  - IDLE: entry empty.
  - WB: entry complete and retiring this cycle.
  - LD_WAIT: load accepted, waiting for its response.
- Transitions:
  - IDLE or WB, transfer of a non-load → WB; data = in_result.
  - IDLE or WB, transfer of a load → LD_WAIT.
  - IDLE or WB, no transfer → IDLE.
  - LD_WAIT, dmem_rvalid → WB; data = aligned(dmem_rdata).
  - LD_WAIT, otherwise → hold.
- in_ready = (state != LD_WAIT). In WB, the retiring entry and the new entry swap in the same edge, giving one instruction per cycle for non-loads.
- Alignment:
  - s = dmem_rdata >> (8 × offset), zero-filled from the top.
  - Byte ops take s[7:0]; half ops take s[15:0]; word ops take s[31:0]; LD takes s.
  - Signed variants sign-extend to 64 bits. Unsigned variants zero-extend.
  - funct3 111 produces 0.
  - Misaligned accesses are not trapped here; they produce the shifted, zero-filled value.
- In WB:
  - rf_we = rd_we && (rd != 0).
  - rf_waddr = rd; rf_wdata = data.
  - commit_valid = 1; commit_pc = pc.
- Outside WB: rf_we = 0 and commit_valid = 0. rf_waddr, rf_wdata and commit_pc hold the entry contents.
- dmem_rvalid outside LD_WAIT is a protocol violation. It is ignored and has no state effect.

## Timing
- Reset: state IDLE, entry cleared to 0. in_ready = 1. rf_we = 0, rf_waddr = 0, rf_wdata = 0, commit_valid = 0, commit_pc = 0.
- Reset mid-load discards the pending entry. A later stale dmem_rvalid is ignored in IDLE.
- Non-load latency: accepted at edge N, rf_we and commit_valid high in cycle N+1.
- Load latency: response at edge M, write in cycle M+1. A response in the cycle after acceptance gives 2 cycles from acceptance to write.
- All outputs except in_ready are driven from registers only. in_ready depends only on state, with no combinational path from in_valid.
- Back-to-back load then ALU: in_ready = 0 throughout LD_WAIT. The ALU instruction is accepted in the load's WB cycle and writes one cycle later, so program order is preserved.

## Structure
- Add to defines.v:
  - load funct3 encodings;
  - state encodings (IDLE, WB, LD_WAIT, 2 bits);
  - XLEN = 64.
- Sub-module `load_align`: combinational; inputs offset[2:0], funct3[2:0], rdata[63:0]; output data[63:0]. It is instantiated once and unit-testable on its own.
- Top level: FSM, entry register, output drive; roughly 150–220 lines total.

## Test plan
- Reset, then ALU op in_rd=5, in_result=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, commit_valid=1, commit_pc=in_pc.
- Three back-to-back ALU ops to x1, x2, x3 with in_valid held high → in_ready stays 1; writes appear on three consecutive cycles.
- Loads with dmem_rdata=0x8877_6655_4433_2211 → expected rf_wdata:
  - LB at offset 7: 0xFFFF_FFFF_FFFF_FF88
  - LBU at offset 7: 0x88
  - LH at offset 6: 0xFFFF_FFFF_FFFF_8877
  - LW at offset 4: 0xFFFF_FFFF_8877_6655
  - LWU at offset 0: 0x4433_2211
  - LD at offset 0: the full value
- Load with a 3-cycle response delay while an ALU op waits → in_ready = 0 for 3 cycles. Then the load writes, and the ALU op writes on the next cycle.
- ALU op with in_rd=0, in_rd_we=1 → rf_we = 0, commit_valid = 1.
- rst_n asserted during LD_WAIT, then dmem_rvalid one cycle after reset is released → no write, no commit, state IDLE.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, load funct3 encodings and writeback FSM states
package wb_stage_pkg;
  localparam int XLEN = 64;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WB      = 2'd1,
    S_LD_WAIT = 2'd2
  } wb_state_e;
endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: shift doubleword load data by byte offset, then size and sign/zero extend per funct3
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);
  logic [XLEN-1:0] s;
  assign s = rdata >> {offset, 3'b000};
  always_comb begin
    data = funct3 == F3_LB  ? {{56{s[7]}}, s[7:0]} :
           funct3 == F3_LH  ? {{48{s[15]}}, s[15:0]} :
           funct3 == F3_LW  ? {{32{s[31]}}, s[31:0]} :
           funct3 == F3_LD  ? s :
           funct3 == F3_LBU ? {56'b0, s[7:0]} :
           funct3 == F3_LHU ? {48'b0, s[15:0]} :
           funct3 == F3_LWU ? {32'b0, s[31:0]} : '0;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage holding one retiring entry, waiting on load responses and driving the register-file write port
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_is_load,
  input  logic [2:0]      in_ld_funct3,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc
);
  wb_state_e       state;
  logic            rd_we;
  logic [2:0]      offset;
  logic [2:0]      funct3;
  logic [XLEN-1:0] aligned;
  load_align u_align (.offset(offset), .funct3(funct3), .rdata(dmem_rdata), .data(aligned));
  assign in_ready = state != S_LD_WAIT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rd_we        <= 1'b0;
      offset       <= '0;
      funct3       <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
    end else if (state == S_LD_WAIT) begin
      if (dmem_rvalid) begin
        state        <= S_WB;
        rf_wdata     <= aligned;
        rf_we        <= rd_we && rf_waddr != 5'd0;
        commit_valid <= 1'b1;
      end
    end else if (in_valid) begin
      state        <= in_is_load ? S_LD_WAIT : S_WB;
      rd_we        <= in_rd_we;
      offset       <= in_result[2:0];
      funct3       <= in_ld_funct3;
      rf_waddr     <= in_rd;
      rf_wdata     <= in_is_load ? rf_wdata : in_result;
      commit_pc    <= in_pc;
      rf_we        <= !in_is_load && in_rd_we && in_rd != 5'd0;
      commit_valid <= !in_is_load;
    end else begin
      state        <= S_IDLE;
      rf_we        <= 1'b0;
      commit_valid <= 1'b0;
    end
  end
endmodule
